// File: rtl/rob_multi_commit.sv
// Reorder buffer with WB_PORTS writeback channels, COMMIT_W-wide in-order retirement
// and precise flush when a mispredicted branch reaches commit.
module rob_multi_commit #(
  parameter int DEPTH    = 16,
  parameter int IDX_W    = 4,
  parameter int WB_PORTS = 2,
  parameter int COMMIT_W = 2,
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int REG_W    = 5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rdy,
  output logic                         full,
  input  logic                         issue_valid,
  input  logic [REG_W-1:0]             issue_rd,
  input  logic                         issue_store,
  input  logic                         issue_pred_jump,
  input  logic                         issue_ready,
  input  logic [DATA_W-1:0]            issue_val,
  output logic [IDX_W-1:0]             issue_idx,
  input  logic [WB_PORTS-1:0]          wb_valid,
  input  logic [WB_PORTS*IDX_W-1:0]    wb_idx,
  input  logic [WB_PORTS*DATA_W-1:0]   wb_val,
  input  logic [WB_PORTS-1:0]          wb_jump,
  input  logic [WB_PORTS*ADDR_W-1:0]   wb_target,
  input  logic [2*IDX_W-1:0]           q_idx,
  output logic [1:0]                   q_ready,
  output logic [2*DATA_W-1:0]          q_val,
  output logic [COMMIT_W-1:0]          commit_valid,
  output logic [COMMIT_W*IDX_W-1:0]    commit_idx,
  output logic [COMMIT_W-1:0]          commit_store,
  output logic [COMMIT_W*REG_W-1:0]    commit_rd,
  output logic [COMMIT_W*DATA_W-1:0]   commit_val,
  output logic                         flush,
  output logic [ADDR_W-1:0]            flush_pc
);

  localparam int CNT_W = IDX_W + 1;

  // Control state (reset) and per-entry payload (not reset).
  logic [IDX_W-1:0]  head_q, tail_q;
  logic [CNT_W-1:0]  count_q;
  logic [DEPTH-1:0]  valid_q, ready_q;
  logic [DEPTH-1:0]  store_q, pjump_q, mispred_q;
  logic [REG_W-1:0]  rd_q     [DEPTH];
  logic [DATA_W-1:0] val_q    [DEPTH];
  logic [ADDR_W-1:0] target_q [DEPTH];

  logic [COMMIT_W-1:0]        commit_valid_q, commit_store_q;
  logic [COMMIT_W*IDX_W-1:0]  commit_idx_q;
  logic [COMMIT_W*REG_W-1:0]  commit_rd_q;
  logic [COMMIT_W*DATA_W-1:0] commit_val_q;
  logic                       flush_q;
  logic [ADDR_W-1:0]          flush_pc_q;

  logic [IDX_W-1:0]    wb_idx_a [WB_PORTS];
  logic [WB_PORTS-1:0] wb_go;
  logic                issue_go;

  logic [IDX_W-1:0]    lane_idx [COMMIT_W];
  logic [COMMIT_W-1:0] take;
  logic [CNT_W-1:0]    n_ret;
  logic                mispred_hit;
  logic [ADDR_W-1:0]   flush_pc_d;

  assign full      = (count_q == CNT_W'(DEPTH));
  assign issue_idx = tail_q;

  // Retire scan over the state held at the start of the cycle; same-cycle
  // writebacks cannot influence it, so commit never depends on wb_* or issue_*.
  // NOTE: every always_comb output is given a default first so no path leaves it unassigned (no latches).
  always_comb begin
    logic stop, store_seen;
    take        = '0;
    n_ret       = '0;
    mispred_hit = 1'b0;
    flush_pc_d  = '0;
    stop        = 1'b0;
    store_seen  = 1'b0;
    for (int l = 0; l < COMMIT_W; l++) begin
      lane_idx[l] = head_q + IDX_W'(l);
      if (!stop && valid_q[lane_idx[l]] && ready_q[lane_idx[l]] &&
          !(store_q[lane_idx[l]] && store_seen)) begin
        take[l]    = 1'b1;
        n_ret      = n_ret + CNT_W'(1);
        store_seen = store_seen | store_q[lane_idx[l]];
        if (mispred_q[lane_idx[l]]) begin
          stop        = 1'b1;
          mispred_hit = 1'b1;
          flush_pc_d  = target_q[lane_idx[l]];
        end
      end else begin
        stop = 1'b1;
      end
    end
  end

  always_comb begin
    for (int p = 0; p < WB_PORTS; p++) begin
      wb_idx_a[p] = wb_idx[p*IDX_W +: IDX_W];
      wb_go[p]    = rdy && !flush_q && !mispred_hit && wb_valid[p] && valid_q[wb_idx_a[p]];
    end
  end

  assign issue_go = rdy && issue_valid && !full && !flush_q && !mispred_hit;

  // Operand query: stored result, overridden by any writeback to the same index this cycle.
  always_comb begin
    q_ready = '0;
    q_val   = '0;
    for (int k = 0; k < 2; k++) begin
      q_ready[k]                = ready_q[q_idx[k*IDX_W +: IDX_W]];
      q_val[k*DATA_W +: DATA_W] = val_q[q_idx[k*IDX_W +: IDX_W]];
      for (int p = 0; p < WB_PORTS; p++) begin
        if (wb_valid[p] && (wb_idx_a[p] == q_idx[k*IDX_W +: IDX_W])) begin
          q_ready[k]                = 1'b1;
          q_val[k*DATA_W +: DATA_W] = wb_val[p*DATA_W +: DATA_W];
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every read sees the pre-edge value.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      valid_q        <= '0;
      ready_q        <= '0;
      commit_valid_q <= '0;
      commit_store_q <= '0;
      commit_idx_q   <= '0;
      commit_rd_q    <= '0;
      commit_val_q   <= '0;
      flush_q        <= 1'b0;
      flush_pc_q     <= '0;
    end else if (!rdy) begin
      commit_valid_q <= '0;
      flush_q        <= 1'b0;
    end else begin
      commit_valid_q <= take;
      for (int l = 0; l < COMMIT_W; l++) begin
        commit_store_q[l]                 <= take[l] & store_q[lane_idx[l]];
        commit_idx_q[l*IDX_W +: IDX_W]    <= lane_idx[l];
        commit_rd_q[l*REG_W +: REG_W]     <= rd_q[lane_idx[l]];
        commit_val_q[l*DATA_W +: DATA_W]  <= val_q[lane_idx[l]];
      end
      flush_q <= mispred_hit;
      if (mispred_hit) begin
        flush_pc_q <= flush_pc_d;
        head_q     <= '0;
        tail_q     <= '0;
        count_q    <= '0;
        valid_q    <= '0;
        ready_q    <= '0;
      end else begin
        for (int p = 0; p < WB_PORTS; p++) begin
          if (wb_go[p]) ready_q[wb_idx_a[p]] <= 1'b1;
        end
        if (issue_go) begin
          valid_q[tail_q] <= 1'b1;
          ready_q[tail_q] <= issue_ready;
          tail_q          <= tail_q + IDX_W'(1);
        end
        for (int l = 0; l < COMMIT_W; l++) begin
          if (take[l]) begin
            valid_q[lane_idx[l]] <= 1'b0;
            ready_q[lane_idx[l]] <= 1'b0;
          end
        end
        head_q  <= head_q + n_ret[IDX_W-1:0];
        count_q <= count_q + CNT_W'(issue_go) - n_ret;
      end
    end
  end

  // NOTE: payload storage carries no reset; valid_q/ready_q gate every use of it.
  // Later ports overwrite earlier ones, so the highest-numbered port wins a collision.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int p = 0; p < WB_PORTS; p++) begin
        if (wb_go[p]) begin
          val_q[wb_idx_a[p]]     <= wb_val[p*DATA_W +: DATA_W];
          target_q[wb_idx_a[p]]  <= wb_target[p*ADDR_W +: ADDR_W];
          mispred_q[wb_idx_a[p]] <= pjump_q[wb_idx_a[p]] ^ wb_jump[p];
        end
      end
      if (issue_go) begin
        rd_q[tail_q]      <= issue_rd;
        val_q[tail_q]     <= issue_val;
        store_q[tail_q]   <= issue_store;
        pjump_q[tail_q]   <= issue_pred_jump;
        mispred_q[tail_q] <= 1'b0;
      end
    end
  end

  assign commit_valid = commit_valid_q;
  assign commit_idx   = commit_idx_q;
  assign commit_store = commit_store_q;
  assign commit_rd    = commit_rd_q;
  assign commit_val   = commit_val_q;
  assign flush        = flush_q;
  assign flush_pc     = flush_pc_q;

endmodule

// File: tb/tb_rob_multi_commit.sv
// Scoreboard bench for rob_multi_commit: expected retirements are queued at issue
// and popped by a commit monitor; directed checks cover full, flush, query and stall.
module tb_rob_multi_commit;

  localparam int IW = 4;
  localparam int WP = 2;
  localparam int CW = 2;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int RW = 5;

  logic clk = 1'b0;
  logic rst, rdy;
  logic full;
  logic issue_valid, issue_store, issue_pred_jump, issue_ready;
  logic [RW-1:0] issue_rd;
  logic [DW-1:0] issue_val;
  logic [IW-1:0] issue_idx;
  logic [WP-1:0] wb_valid, wb_jump;
  logic [WP*IW-1:0] wb_idx;
  logic [WP*DW-1:0] wb_val;
  logic [WP*AW-1:0] wb_target;
  logic [2*IW-1:0] q_idx;
  logic [1:0] q_ready;
  logic [2*DW-1:0] q_val;
  logic [CW-1:0] commit_valid, commit_store;
  logic [CW*IW-1:0] commit_idx;
  logic [CW*RW-1:0] commit_rd;
  logic [CW*DW-1:0] commit_val;
  logic flush;
  logic [AW-1:0] flush_pc;

  rob_multi_commit dut (
    .clk(clk), .rst(rst), .rdy(rdy), .full(full),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_store(issue_store),
    .issue_pred_jump(issue_pred_jump), .issue_ready(issue_ready), .issue_val(issue_val),
    .issue_idx(issue_idx),
    .wb_valid(wb_valid), .wb_idx(wb_idx), .wb_val(wb_val), .wb_jump(wb_jump), .wb_target(wb_target),
    .q_idx(q_idx), .q_ready(q_ready), .q_val(q_val),
    .commit_valid(commit_valid), .commit_idx(commit_idx), .commit_store(commit_store),
    .commit_rd(commit_rd), .commit_val(commit_val),
    .flush(flush), .flush_pc(flush_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [IW-1:0] idx;
    logic [RW-1:0] rd;
    logic [DW-1:0] val;
    logic          st;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_pass   = 0;
  logic [IW-1:0] exp_tail;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Commit monitor: every retiring lane must match the oldest expected entry.
  always @(negedge clk) begin
    if (!rst && commit_valid != '0) begin
      check("commit_contig", 64'((commit_valid & (commit_valid + 1'b1)) == '0), 64'd1);
      for (int l = 0; l < CW; l++) begin
        if (commit_valid[l]) begin
          check("commit_expected", 64'(sb.size() > 0), 64'd1);
          if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check("commit_idx", 64'(commit_idx[l*IW +: IW]), 64'(e.idx));
            check("commit_rd", 64'(commit_rd[l*RW +: RW]), 64'(e.rd));
            check("commit_val", 64'(commit_val[l*DW +: DW]), 64'(e.val));
            check("commit_store", 64'(commit_store[l]), 64'(e.st));
          end
        end
      end
    end
  end

  task automatic clear_inputs();
    issue_valid = 0; issue_rd = '0; issue_store = 0; issue_pred_jump = 0;
    issue_ready = 0; issue_val = '0;
    wb_valid = '0; wb_idx = '0; wb_val = '0; wb_jump = '0; wb_target = '0;
  endtask

  task automatic set_wb(input int p, input logic [IW-1:0] idx, input logic [DW-1:0] v,
                        input logic jmp, input logic [AW-1:0] tgt);
    wb_valid[p]            = 1'b1;
    wb_idx[p*IW +: IW]     = idx;
    wb_val[p*DW +: DW]     = v;
    wb_jump[p]             = jmp;
    wb_target[p*AW +: AW]  = tgt;
  endtask

  task automatic clear_wb();
    wb_valid = '0; wb_idx = '0; wb_val = '0; wb_jump = '0; wb_target = '0;
  endtask

  // One issue cycle; the expected retirement record is queued when push is set.
  task automatic do_issue(input logic [RW-1:0] rd, input logic st, input logic pj,
                          input logic rdyi, input logic [DW-1:0] v, input bit push);
    exp_t e;
    issue_valid = 1; issue_rd = rd; issue_store = st; issue_pred_jump = pj;
    issue_ready = rdyi; issue_val = v;
    check("issue_idx", 64'(issue_idx), 64'(exp_tail));
    if (push) begin
      e.idx = exp_tail; e.rd = rd; e.val = v; e.st = st;
      sb.push_back(e);
    end
    @(negedge clk);
    issue_valid = 0;
    exp_tail = exp_tail + 1'b1;
  endtask

  task automatic drain();
    for (int c = 0; c < 60 && sb.size() != 0; c++) begin
      @(negedge clk); #1;
    end
    check("drain_empty", 64'(sb.size()), 64'd0);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clear_inputs();
    q_idx = '0;
    rst = 1; rdy = 1;
    exp_tail = '0;
    repeat (3) @(negedge clk);
    check("rst_full", 64'(full), 64'd0);
    check("rst_commit_valid", 64'(commit_valid), 64'd0);
    check("rst_commit_store", 64'(commit_store), 64'd0);
    check("rst_commit_idx", 64'(commit_idx), 64'd0);
    check("rst_commit_val", 64'(commit_val), 64'd0);
    check("rst_flush", 64'(flush), 64'd0);
    check("rst_flush_pc", 64'(flush_pc), 64'd0);
    check("rst_issue_idx", 64'(issue_idx), 64'd0);
    check("rst_q_ready", 64'(q_ready), 64'd0);
    rst = 0;
    @(negedge clk);

    // 1: fill all 16 entries, overflow attempt ignored, tail wraps to 0.
    for (int i = 0; i < 16; i++) begin
      check("fill_not_full", 64'(full), 64'd0);
      do_issue(RW'(i + 1), 1'b0, 1'b0, 1'b0, 32'h100 + 32'(i), 1'b1);
    end
    check("full_after_16", 64'(full), 64'd1);
    issue_valid = 1; issue_ready = 1; issue_val = 32'hBAD0;
    check("idx_wrap", 64'(issue_idx), 64'd0);
    @(negedge clk);
    issue_valid = 0;
    check("full_after_17", 64'(full), 64'd1);
    check("idx_after_17", 64'(issue_idx), 64'd0);
    for (int i = 0; i < 16; i += 2) begin
      set_wb(0, IW'(i), 32'h100 + 32'(i), 1'b0, '0);
      set_wb(1, IW'(i + 1), 32'h101 + 32'(i), 1'b0, '0);
      @(negedge clk);
    end
    clear_wb();
    drain();
    check("empty_not_full", 64'(full), 64'd0);

    // 2: blocked head, then two full-width commit groups {0,1},{2,3}.
    do_issue(5'd3, 1'b0, 1'b0, 1'b0, 32'hA0, 1'b1);
    do_issue(5'd4, 1'b0, 1'b0, 1'b1, 32'hA1, 1'b1);
    do_issue(5'd5, 1'b0, 1'b0, 1'b1, 32'hA2, 1'b1);
    do_issue(5'd6, 1'b0, 1'b0, 1'b1, 32'hA3, 1'b1);
    check("t2_no_commit_yet", 64'(commit_valid), 64'd0);
    set_wb(0, 4'd0, 32'hA0, 1'b0, '0);
    @(negedge clk);
    clear_wb();
    check("t2_wb_edge_no_commit", 64'(commit_valid), 64'd0);
    @(negedge clk);
    check("t2_group0_valid", 64'(commit_valid), 64'b11);
    check("t2_group0_idx", 64'(commit_idx), 64'({4'd1, 4'd0}));
    @(negedge clk);
    check("t2_group1_valid", 64'(commit_valid), 64'b11);
    check("t2_group1_idx", 64'(commit_idx), 64'({4'd3, 4'd2}));
    @(negedge clk);
    check("t2_idle", 64'(commit_valid), 64'd0);

    // 3: out-of-order writebacks on both ports retire together; next entry blocks.
    do_issue(5'd7, 1'b0, 1'b0, 1'b0, 32'hB4, 1'b1);
    do_issue(5'd8, 1'b0, 1'b0, 1'b0, 32'hB5, 1'b1);
    do_issue(5'd9, 1'b0, 1'b0, 1'b0, 32'hB6, 1'b1);
    set_wb(0, 4'd5, 32'hB5, 1'b0, '0);
    set_wb(1, 4'd4, 32'hB4, 1'b0, '0);
    @(negedge clk);
    clear_wb();
    @(negedge clk);
    check("t3_pair_valid", 64'(commit_valid), 64'b11);
    check("t3_pair_idx", 64'(commit_idx), 64'({4'd5, 4'd4}));
    @(negedge clk);
    check("t3_blocked", 64'(commit_valid), 64'd0);
    set_wb(0, 4'd6, 32'hB6, 1'b0, '0);
    @(negedge clk);
    clear_wb();
    drain();

    // 4: mispredicted branch retires as last lane, younger ready entries squashed.
    do_issue(5'd10, 1'b0, 1'b0, 1'b0, 32'hC7, 1'b1);
    do_issue(5'd11, 1'b0, 1'b0, 1'b0, 32'hC8, 1'b1);
    do_issue(5'd12, 1'b0, 1'b0, 1'b1, 32'hC9, 1'b0);
    do_issue(5'd13, 1'b0, 1'b0, 1'b1, 32'hCA, 1'b0);
    set_wb(0, 4'd7, 32'hC7, 1'b0, 32'h0);
    set_wb(1, 4'd8, 32'hC8, 1'b1, 32'h1000);
    @(negedge clk);
    clear_wb();
    check("t4_pre_flush", 64'(flush), 64'd0);
    @(negedge clk);
    check("t4_commit_valid", 64'(commit_valid), 64'b11);
    check("t4_branch_last_lane", 64'(commit_idx[IW +: IW]), 64'd8);
    check("t4_flush", 64'(flush), 64'd1);
    check("t4_flush_pc", 64'(flush_pc), 64'h1000);
    check("t4_tail_reset", 64'(issue_idx), 64'd0);
    check("t4_not_full", 64'(full), 64'd0);
    issue_valid = 1; issue_ready = 1; issue_val = 32'hDEAD;
    @(negedge clk);
    issue_valid = 0; issue_ready = 0;
    check("t4_flush_one_cycle", 64'(flush), 64'd0);
    check("t4_issue_ignored", 64'(issue_idx), 64'd0);
    check("t4_no_more_commit", 64'(commit_valid), 64'd0);
    exp_tail = '0;
    repeat (3) @(negedge clk);

    // 5: two ready stores retire one per cycle.
    do_issue(5'd0, 1'b1, 1'b0, 1'b0, 32'hD0, 1'b1);
    do_issue(5'd0, 1'b1, 1'b0, 1'b1, 32'hD1, 1'b1);
    set_wb(0, 4'd0, 32'hD0, 1'b0, '0);
    @(negedge clk);
    clear_wb();
    @(negedge clk);
    check("t5_store0_valid", 64'(commit_valid), 64'b01);
    check("t5_store0_flag", 64'(commit_store), 64'b01);
    @(negedge clk);
    check("t5_store1_valid", 64'(commit_valid), 64'b01);
    check("t5_store1_flag", 64'(commit_store), 64'b01);
    check("t5_store1_idx", 64'(commit_idx[IW-1:0]), 64'd1);
    @(negedge clk);
    check("t5_idle", 64'(commit_valid), 64'd0);

    // 6: query bypass, then a 3-cycle rdy=0 stall.
    do_issue(5'd20, 1'b0, 1'b0, 1'b0, 32'hABCD, 1'b1);
    do_issue(5'd21, 1'b0, 1'b0, 1'b0, 32'hE3, 1'b1);
    q_idx = {4'd3, 4'd2};
    #1;
    check("t6_q_not_ready", 64'(q_ready), 64'b00);
    set_wb(0, 4'd2, 32'hABCD, 1'b0, '0);
    #1;
    check("t6_q_bypass_ready", 64'(q_ready), 64'b01);
    check("t6_q_bypass_val", 64'(q_val[DW-1:0]), 64'hABCD);
    @(negedge clk);
    clear_wb();
    rdy = 0;
    issue_valid = 1; issue_ready = 1; issue_val = 32'hBEEF;
    set_wb(0, 4'd3, 32'h5555, 1'b0, '0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("t6_stall_no_commit", 64'(commit_valid), 64'd0);
      check("t6_stall_tail", 64'(issue_idx), 64'd4);
    end
    clear_inputs();
    rdy = 1;
    #1;
    check("t6_stall_state_kept", 64'(q_ready), 64'b01);
    check("t6_stored_val", 64'(q_val[DW-1:0]), 64'hABCD);
    @(negedge clk);
    check("t6_resume_valid", 64'(commit_valid), 64'b01);
    check("t6_resume_idx", 64'(commit_idx[IW-1:0]), 64'd2);
    set_wb(0, 4'd3, 32'hE3, 1'b0, '0);
    @(negedge clk);
    clear_wb();
    drain();
    check("final_sb_empty", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
